dealloc_unit: RTL and testbench

- Deallocation controller of the MPU.
- Accepts a free request (address + requesting core), looks up the block's entry in the allocation control table (ACT), and checks ownership.
- On success, invalidates every contiguous ACT entry of that reservation and returns the reservation ID to the reservation-ID free queue.
- Sits between the core request arbiter, the ACT memory's dealloc port and the reservation counter's enqueue port.

---
 rtl/dealloc_unit_pkg.sv | 28 ++
 rtl/dealloc_unit_if.sv | 28 ++
 rtl/dealloc_unit.sv | 128 ++++++++++++
 tb/tb_dealloc_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dealloc_unit_pkg.sv
// Shared MPU types: widths, ACT entry layout and deallocator FSM encoding.
// Imported by the deallocation interface and controller.
package mpu_common;

    localparam int ADDR_WIDTH       = 32;
    localparam int CORE_ID_WIDTH    = 4;
    localparam int BLOCK_COUNT_BITS = 6;
    localparam int REGION_SHIFT     = 12;
    localparam int MASK_WIDTH       = 16;

    typedef struct packed {
        logic                        valid;
        logic [MASK_WIDTH-1:0]       write_mask;
        logic [MASK_WIDTH-1:0]       read_mask;
        logic [CORE_ID_WIDTH-1:0]    owner;
        logic [BLOCK_COUNT_BITS-1:0] reservation_id;
    } entry_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_CHK  = 2'd2;
    localparam state_t ST_ENQ  = 2'd3;

    localparam logic [BLOCK_COUNT_BITS-1:0] LAST_BLOCK = '1;

endpackage

// File: rtl/dealloc_unit_if.sv
// ACT dealloc-port bus between the deallocator (master) and the ACT memory (slave).
// Ports: act_cs/act_we/act_addr/act_wdata toward memory, act_rdata back (1-cycle latency).
interface dealloc_unit_if;
    import mpu_common::*;

    logic                        act_cs;
    logic                        act_we;
    entry_t                      act_wdata;
    logic [BLOCK_COUNT_BITS-1:0] act_addr;
    entry_t                      act_rdata;

    modport master (
        output act_cs,
        output act_we,
        output act_wdata,
        output act_addr,
        input  act_rdata
    );

    modport slave (
        input  act_cs,
        input  act_we,
        input  act_wdata,
        input  act_addr,
        output act_rdata
    );

endinterface

// File: rtl/dealloc_unit.sv
// MPU deallocation controller: checks ownership of the named block, clears the
// reservation's contiguous ACT entries and enqueues the freed reservation ID.
// Ports: clk, rst (async, active-high), cs/addr/core_id request, act (ACT bus
// master), reservation_id_out/reservation_enqueue, bsy/rdy/err status.
module dealloc_unit
    import mpu_common::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cs,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [CORE_ID_WIDTH-1:0]    core_id,
    dealloc_unit_if.master              act,
    output logic [BLOCK_COUNT_BITS-1:0] reservation_id_out,
    output logic                        reservation_enqueue,
    output logic                        bsy,
    output logic                        rdy,
    output logic                        err
);

    state_t                      state;
    logic [BLOCK_COUNT_BITS-1:0] idx;
    logic [CORE_ID_WIDTH-1:0]    core_q;
    logic [BLOCK_COUNT_BITS-1:0] rid;
    logic                        first;

    entry_t rd_entry;
    logic   owner_ok;
    logic   cont_ok;
    logic   do_write;

    // Only the block-index field of the address selects an entry.
    logic unused_bits;
    assign unused_bits = &{1'b0,
                           addr[ADDR_WIDTH-1:REGION_SHIFT+BLOCK_COUNT_BITS],
                           addr[REGION_SHIFT-1:0],
                           rd_entry.write_mask,
                           rd_entry.read_mask};

    assign rd_entry = act.act_rdata;
    assign owner_ok = rd_entry.valid && (rd_entry.owner == core_q);
    assign cont_ok  = owner_ok && (rd_entry.reservation_id == rid);

    // First block must belong to the core; later blocks must also carry the
    // reservation ID captured from the first one.
    assign do_write = (state == ST_CHK) && (first ? owner_ok : cont_ok);

    always_comb begin
        act.act_cs    = 1'b0;
        act.act_we    = 1'b0;
        act.act_addr  = '0;
        act.act_wdata = '0;
        case (state)
            ST_RD: begin
                act.act_cs   = 1'b1;
                act.act_addr = idx;
            end
            ST_CHK: begin
                act.act_cs   = do_write;
                act.act_we   = do_write;
                act.act_addr = idx;
            end
            default: ;
        endcase
    end

    assign bsy                 = (state != ST_IDLE);
    assign reservation_enqueue = (state == ST_ENQ);
    assign reservation_id_out  = rid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            core_q <= '0;
            rid    <= '0;
            first  <= 1'b0;
            rdy    <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs) begin
                        idx    <= addr[REGION_SHIFT +: BLOCK_COUNT_BITS];
                        core_q <= core_id;
                        first  <= 1'b1;
                        rdy    <= 1'b0;
                        err    <= 1'b0;
                        state  <= ST_RD;
                    end
                end
                ST_RD: begin
                    state <= ST_CHK;
                end
                ST_CHK: begin
                    if (first && !owner_ok) begin
                        err   <= 1'b1;
                        rdy   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (do_write) begin
                        if (first) begin
                            rid   <= rd_entry.reservation_id;
                            first <= 1'b0;
                        end
                        // Scan stops at the top of the table, never wraps.
                        if (idx == LAST_BLOCK) begin
                            state <= ST_ENQ;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_RD;
                        end
                    end else begin
                        state <= ST_ENQ;
                    end
                end
                ST_ENQ: begin
                    rdy   <= 1'b1;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dealloc_unit.sv
// Self-checking bench for dealloc_unit with an ACT memory model and a
// reservation free-queue scoreboard.
module tb_dealloc_unit;
    import mpu_common::*;

    logic                        clk;
    logic                        rst;
    logic                        cs;
    logic [ADDR_WIDTH-1:0]       addr;
    logic [CORE_ID_WIDTH-1:0]    core_id;
    logic [BLOCK_COUNT_BITS-1:0] reservation_id_out;
    logic                        reservation_enqueue;
    logic                        bsy;
    logic                        rdy;
    logic                        err;

    dealloc_unit_if act_bus ();

    dealloc_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .cs                  (cs),
        .addr                (addr),
        .core_id             (core_id),
        .act                 (act_bus),
        .reservation_id_out  (reservation_id_out),
        .reservation_enqueue (reservation_enqueue),
        .bsy                 (bsy),
        .rdy                 (rdy),
        .err                 (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    entry_t mem [0:(1<<BLOCK_COUNT_BITS)-1];
    int     write_cnt = 0;
    int     enq_cnt   = 0;
    logic [BLOCK_COUNT_BITS-1:0] exp_q  [$];
    logic [BLOCK_COUNT_BITS-1:0] free_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ACT memory model: synchronous read, write on cs&we edge.
    always @(posedge clk) begin
        if (act_bus.act_cs === 1'b1) begin
            if (act_bus.act_we === 1'b1) begin
                mem[act_bus.act_addr] <= act_bus.act_wdata;
                write_cnt = write_cnt + 1;
            end else begin
                act_bus.act_rdata <= mem[act_bus.act_addr];
            end
        end
    end

    // Reservation counter model plus scoreboard compare on each enqueue.
    always @(negedge clk) begin
        if (reservation_enqueue === 1'b1) begin
            enq_cnt = enq_cnt + 1;
            free_q.push_back(reservation_id_out);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL enq_unexpected: rid=%0d, none expected",
                         reservation_id_out);
                n_fail++;
            end else begin
                logic [BLOCK_COUNT_BITS-1:0] e;
                e = exp_q.pop_front();
                if (reservation_id_out !== e) begin
                    $display("FAIL enq_rid: got %0d expected %0d",
                             reservation_id_out, e);
                    n_fail++;
                end
            end
        end
    end

    function automatic entry_t mk(input logic [CORE_ID_WIDTH-1:0] o,
                                  input logic [BLOCK_COUNT_BITS-1:0] r);
        entry_t e;
        e.valid          = 1'b1;
        e.write_mask     = 16'hFFFF;
        e.read_mask      = 16'h00FF;
        e.owner          = o;
        e.reservation_id = r;
        return e;
    endfunction

    task automatic run_free(input logic [ADDR_WIDTH-1:0] a,
                            input logic [CORE_ID_WIDTH-1:0] c,
                            output int cycles);
        @(negedge clk);
        addr    = a;
        core_id = c;
        cs      = 1'b1;
        @(negedge clk);
        cs      = 1'b0;
        cycles  = 0;
        while (bsy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (cycles >= 200) begin
            $display("FAIL timeout: bsy stuck after %0d cycles", cycles);
            n_fail++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cs = 1'b0;
        addr = '0;
        core_id = '0;
        act_bus.act_rdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bsy, rdy, err, reservation_enqueue, act_bus.act_cs,
             act_bus.act_we} !== 6'b0) begin
            $display("FAIL reset_ctrl: bsy=%b rdy=%b err=%b enq=%b cs=%b we=%b",
                     bsy, rdy, err, reservation_enqueue,
                     act_bus.act_cs, act_bus.act_we);
            n_fail++;
        end
        n_checks++;
        if (act_bus.act_wdata !== '0 || act_bus.act_addr !== '0 ||
            reservation_id_out !== '0) begin
            $display("FAIL reset_data: wdata=%h addr=%0d rid=%0d expected 0",
                     act_bus.act_wdata, act_bus.act_addr, reservation_id_out);
            n_fail++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic init_table;
        for (int i = 0; i < (1<<BLOCK_COUNT_BITS); i++) mem[i] = '0;
        mem[0] = mk(4'd1, 6'd0);
        mem[1] = mk(4'd1, 6'd0);
        mem[2] = mk(4'd0, 6'd1);
        mem[3] = mk(4'd0, 6'd1);
        mem[4] = mk(4'd2, 6'd2);
        mem[5] = mk(4'd2, 6'd2);
    endtask

    task automatic test_wrong_owner;
        int cyc, w0, q0;
        w0 = write_cnt;
        q0 = enq_cnt;
        run_free(32'h0000_0000, 4'd2, cyc);
        n_checks++;
        if (err !== 1'b1 || rdy !== 1'b1) begin
            $display("FAIL wrong_owner_status: err=%b rdy=%b expected 1 1",
                     err, rdy);
            n_fail++;
        end
        n_checks++;
        if (write_cnt != w0 || enq_cnt != q0) begin
            $display("FAIL wrong_owner_side: writes=%0d enq=%0d expected 0 0",
                     write_cnt - w0, enq_cnt - q0);
            n_fail++;
        end
        n_checks++;
        if (cyc != 2) begin
            $display("FAIL wrong_owner_lat: got %0d expected 2", cyc);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (mem[i].valid !== 1'b1) begin
                $display("FAIL wrong_owner_entry%0d: valid=%b expected 1",
                         i, mem[i].valid);
                n_fail++;
            end
        end
    endtask

    task automatic test_valid_free;
        int cyc, w0, q0;
        w0 = write_cnt;
        q0 = enq_cnt;
        exp_q.push_back(6'd1);
        run_free(32'd2 << REGION_SHIFT, 4'd0, cyc);
        n_checks++;
        if (err !== 1'b0 || rdy !== 1'b1) begin
            $display("FAIL valid_status: err=%b rdy=%b expected 0 1", err, rdy);
            n_fail++;
        end
        n_checks++;
        if (mem[2] !== '0 || mem[3] !== '0) begin
            $display("FAIL valid_cleared: e2=%h e3=%h expected 0", mem[2], mem[3]);
            n_fail++;
        end
        n_checks++;
        if ({mem[0].valid, mem[1].valid, mem[4].valid, mem[5].valid} !== 4'hF) begin
            $display("FAIL valid_intact: v0145=%b%b%b%b expected 1111",
                     mem[0].valid, mem[1].valid, mem[4].valid, mem[5].valid);
            n_fail++;
        end
        n_checks++;
        if (write_cnt - w0 != 2 || enq_cnt - q0 != 1) begin
            $display("FAIL valid_counts: writes=%0d enq=%0d expected 2 1",
                     write_cnt - w0, enq_cnt - q0);
            n_fail++;
        end
        n_checks++;
        if (cyc != 7) begin
            $display("FAIL valid_lat: got %0d expected 7", cyc);
            n_fail++;
        end
        n_checks++;
        if (free_q.size() == 0 || free_q[free_q.size()-1] !== 6'd1) begin
            $display("FAIL valid_tail: size=%0d expected tail 1", free_q.size());
            n_fail++;
        end
    endtask

    task automatic test_empty;
        int cyc, w0, q0;
        w0 = write_cnt;
        q0 = enq_cnt;
        run_free(32'd10 << REGION_SHIFT, 4'd0, cyc);
        n_checks++;
        if (err !== 1'b1 || rdy !== 1'b1) begin
            $display("FAIL empty_status: err=%b rdy=%b expected 1 1", err, rdy);
            n_fail++;
        end
        n_checks++;
        if (write_cnt != w0 || enq_cnt != q0) begin
            $display("FAIL empty_side: writes=%0d enq=%0d expected 0 0",
                     write_cnt - w0, enq_cnt - q0);
            n_fail++;
        end
    endtask

    task automatic test_top_boundary;
        int cyc, w0, q0;
        logic [ADDR_WIDTH-1:0] a;
        mem[62] = mk(4'd3, 6'd5);
        mem[63] = mk(4'd3, 6'd5);
        w0 = write_cnt;
        q0 = enq_cnt;
        exp_q.push_back(6'd5);
        // Upper address bits and in-block offset must not matter.
        a = 32'hABC0_0000 | (32'd62 << REGION_SHIFT) | 32'h0000_0ABC;
        run_free(a, 4'd3, cyc);
        n_checks++;
        if (mem[62].valid !== 1'b0 || mem[63].valid !== 1'b0) begin
            $display("FAIL top_cleared: v62=%b v63=%b expected 0 0",
                     mem[62].valid, mem[63].valid);
            n_fail++;
        end
        n_checks++;
        if (mem[0].valid !== 1'b1 || write_cnt - w0 != 2) begin
            $display("FAIL top_wrap: v0=%b writes=%0d expected 1 2",
                     mem[0].valid, write_cnt - w0);
            n_fail++;
        end
        n_checks++;
        if (cyc != 5 || enq_cnt - q0 != 1 || err !== 1'b0) begin
            $display("FAIL top_done: lat=%0d enq=%0d err=%b expected 5 1 0",
                     cyc, enq_cnt - q0, err);
            n_fail++;
        end
    endtask

    task automatic test_cs_while_busy;
        int w0, q0, cnt;
        w0 = write_cnt;
        q0 = enq_cnt;
        exp_q.push_back(6'd2);
        @(negedge clk);
        addr = 32'd4 << REGION_SHIFT;
        core_id = 4'd2;
        cs = 1'b1;
        @(negedge clk);
        addr = 32'd0;
        core_id = 4'd1;
        repeat (3) @(negedge clk);
        cs = 1'b0;
        cnt = 0;
        while (bsy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (cnt >= 200 || bsy !== 1'b0) begin
            $display("FAIL busy_timeout: cycles=%0d bsy=%b", cnt, bsy);
            n_fail++;
        end
        n_checks++;
        if (mem[4].valid !== 1'b0 || mem[5].valid !== 1'b0 ||
            mem[0].valid !== 1'b1 || mem[1].valid !== 1'b1) begin
            $display("FAIL busy_entries: v0=%b v1=%b v4=%b v5=%b expected 1 1 0 0",
                     mem[0].valid, mem[1].valid, mem[4].valid, mem[5].valid);
            n_fail++;
        end
        n_checks++;
        if (write_cnt - w0 != 2 || enq_cnt - q0 != 1 || err !== 1'b0) begin
            $display("FAIL busy_counts: writes=%0d enq=%0d err=%b expected 2 1 0",
                     write_cnt - w0, enq_cnt - q0, err);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid;
        int w0, q0, cnt;
        mem[20] = mk(4'd4, 6'd7);
        mem[21] = mk(4'd4, 6'd7);
        w0 = write_cnt;
        q0 = enq_cnt;
        @(negedge clk);
        addr = 32'd20 << REGION_SHIFT;
        core_id = 4'd4;
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        cnt = 0;
        while (write_cnt == w0 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (act_bus.act_we !== 1'b1 || act_bus.act_addr !== 6'd21) begin
            $display("FAIL mid_pre: we=%b addr=%0d expected 1 21",
                     act_bus.act_we, act_bus.act_addr);
            n_fail++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bsy, rdy, err, reservation_enqueue, act_bus.act_cs,
             act_bus.act_we} !== 6'b0 || act_bus.act_addr !== '0 ||
            reservation_id_out !== '0) begin
            $display("FAIL mid_rst_out: bsy=%b cs=%b we=%b enq=%b rid=%0d",
                     bsy, act_bus.act_cs, act_bus.act_we,
                     reservation_enqueue, reservation_id_out);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (mem[20].valid !== 1'b0 || mem[21].valid !== 1'b1) begin
            $display("FAIL mid_entries: v20=%b v21=%b expected 0 1",
                     mem[20].valid, mem[21].valid);
            n_fail++;
        end
        n_checks++;
        if (write_cnt - w0 != 1 || enq_cnt != q0) begin
            $display("FAIL mid_side: writes=%0d enq=%0d expected 1 0",
                     write_cnt - w0, enq_cnt - q0);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        init_table();
        test_wrong_owner();
        test_valid_free();
        test_empty();
        test_top_boundary();
        test_cs_while_busy();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL enq_missing: %0d expected enqueues never seen",
                     exp_q.size());
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
